// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: on-chip backing store for the 64-bit pmem burst bus.
// Serves line reads/writes as 4 beats after LATENCY cycles and flags protocol errors.
// Ports:
//   clk, rst                 clock, async active-high reset
//   pmem_read, pmem_write    held line request (read wins if both)
//   pmem_address             byte address, [5+IDX_BITS-1:5] selects the line
//   pmem_wdata               write beat, sampled while pmem_resp=1
//   pmem_resp                beat strobe, 4 consecutive cycles per burst
//   pmem_rdata               registered read beat, 0 when not reading
//   proto_err                sticky protocol-violation flag
module pmem_burst_responder #(
  parameter int LATENCY  = 4,
  parameter int IDX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic        pmem_resp,
  output logic [63:0] pmem_rdata,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          wait_cnt;
  logic [1:0]          beat;
  logic [1:0]          next_beat;
  logic                op_rd;
  logic [31:0]         cap_addr;
  logic [IDX_BITS-1:0] line;
  logic [IDX_BITS-1:0] req_idx;
  logic                viol;

  logic [63:0] mem [2**(IDX_BITS+2)];

  assign req_idx   = pmem_address[5+IDX_BITS-1:5];
  assign next_beat = beat + 2'd1;

  // Held request must match the captured op and address for the whole burst.
  always_comb begin
    viol = 1'b0;
    if (op_rd)
      viol = !pmem_read || pmem_write;
    else
      viol = !pmem_write || pmem_read;
    if (pmem_address != cap_addr)
      viol = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      beat       <= '0;
      op_rd      <= 1'b0;
      cap_addr   <= '0;
      line       <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pmem_read || pmem_write) begin
            op_rd    <= pmem_read;
            cap_addr <= pmem_address;
            line     <= req_idx;
            beat     <= '0;
            if (pmem_read && pmem_write)
              proto_err <= 1'b1;
            if (LATENCY == 1) begin
              state      <= BURST;
              pmem_resp  <= 1'b1;
              pmem_rdata <= pmem_read ? mem[{req_idx, 2'd0}] : '0;
            end else begin
              state    <= WAIT;
              wait_cnt <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (viol)
            proto_err <= 1'b1;
          wait_cnt <= wait_cnt - 4'd1;
          // Counter reaching zero lands the first beat in cycle LATENCY.
          if (wait_cnt == 4'd1) begin
            state      <= BURST;
            beat       <= '0;
            pmem_resp  <= 1'b1;
            pmem_rdata <= op_rd ? mem[{line, 2'd0}] : '0;
          end
        end
        BURST: begin
          if (viol)
            proto_err <= 1'b1;
          beat <= next_beat;
          if (beat == 2'd3) begin
            state      <= DONE;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
          end else begin
            // Prefetch the next beat so rdata is a clean register output.
            pmem_rdata <= op_rd ? mem[{line, next_beat}] : '0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; reset forces IDLE so no further beats land.
  always_ff @(posedge clk) begin
    if (state == BURST && !op_rd)
      mem[{line, beat}] <= pmem_wdata;
  end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// tb_pmem_burst_responder: directed bench for pmem_burst_responder.
// Covers latency, data, aliasing, protocol errors and reset mid-burst.
module tb_pmem_burst_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pmem_read = 1'b0;
  logic        pmem_write = 1'b0;
  logic [31:0] pmem_address = '0;
  logic [63:0] pmem_wdata = '0;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;
  logic        proto_err;

  logic        r1 = 1'b0;
  logic        w1 = 1'b0;
  logic [31:0] a1 = '0;
  logic [63:0] wd1 = '0;
  logic        resp1;
  logic [63:0] rdata1;
  logic        err1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pmem_burst_responder #(.LATENCY(LAT), .IDX_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_resp   (pmem_resp),
    .pmem_rdata  (pmem_rdata),
    .proto_err   (proto_err)
  );

  pmem_burst_responder #(.LATENCY(1), .IDX_BITS(8)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .pmem_read   (r1),
    .pmem_write  (w1),
    .pmem_address(a1),
    .pmem_wdata  (wd1),
    .pmem_resp   (resp1),
    .pmem_rdata  (rdata1),
    .proto_err   (err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full burst on the LATENCY=4 instance, starting at a cycle start.
  // d0..d3 are write data for writes, expected beats for reads.
  task automatic burst(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2, input logic [63:0] d3,
                       input logic chg, input logic [31:0] chg_addr);
    logic [63:0] d[4];
    logic        in_b;
    d = '{d0, d1, d2, d3};
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    for (int c = 0; c <= LAT + 4; c++) begin
      in_b = (c >= LAT) && (c <= LAT + 3);
      if (in_b && wr && !rd)
        pmem_wdata = d[c-LAT];
      if (chg && c == LAT + 1)
        pmem_address = chg_addr;
      if (c == LAT + 4) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("%s resp c%0d", tag, c), 64'(pmem_resp), 64'(in_b));
      if (rd && in_b)
        chk($sformatf("%s rdata b%0d", tag, c - LAT), pmem_rdata, d[c-LAT]);
      if (c >= LAT && (!rd || c == LAT + 4))
        chk($sformatf("%s rdata0 c%0d", tag, c), pmem_rdata, 64'h0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, " err"}, 64'(proto_err), 64'h0);
    chk({tag, " resp"}, 64'(pmem_resp), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] nw[4];
    logic        exp1;
    nw = '{64'h9999_0000_0000_0000, 64'h9999_1111_1111_1111,
           64'h9999_2222_2222_2222, 64'h9999_3333_3333_3333};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset resp", 64'(pmem_resp), 64'h0);
    chk("reset rdata", pmem_rdata, 64'h0);
    chk("reset err", 64'(proto_err), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    burst("wr A0", 1'b0, 1'b1, 32'h0000_00A0,
          64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b0, '0);
    burst("rd A0", 1'b1, 1'b0, 32'h0000_00A0,
          64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b0, '0);
    chk("clean err", 64'(proto_err), 64'h0);

    burst("wr alias", 1'b0, 1'b1, 32'h0000_0A1F,
          64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
          64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4, 1'b0, '0);
    burst("rd alias", 1'b1, 1'b0, 32'h8000_0A00,
          64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
          64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4, 1'b0, '0);
    chk("alias err", 64'(proto_err), 64'h0);

    pmem_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
    burst("rdwr A0", 1'b1, 1'b1, 32'h0000_00A0,
          64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b0, '0);
    chk("rdwr err", 64'(proto_err), 64'h1);
    burst("rd A0 again", 1'b1, 1'b0, 32'h0000_00A0,
          64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
          64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b0, '0);
    chk("err sticky", 64'(proto_err), 64'h1);
    pulse_rst("rst1");

    burst("wr 200", 1'b0, 1'b1, 32'h0000_0200,
          64'h2000_0000_0000_0000, 64'h2000_0000_0000_0001,
          64'h2000_0000_0000_0002, 64'h2000_0000_0000_0003, 1'b0, '0);
    chk("pre chg err", 64'(proto_err), 64'h0);
    burst("wr 100 chg", 1'b0, 1'b1, 32'h0000_0100,
          64'h5555_0000_0000_0000, 64'h5555_0000_0000_0001,
          64'h5555_0000_0000_0002, 64'h5555_0000_0000_0003,
          1'b1, 32'h0000_0200);
    chk("chg err", 64'(proto_err), 64'h1);
    burst("rd 100", 1'b1, 1'b0, 32'h0000_0100,
          64'h5555_0000_0000_0000, 64'h5555_0000_0000_0001,
          64'h5555_0000_0000_0002, 64'h5555_0000_0000_0003, 1'b0, '0);
    burst("rd 200", 1'b1, 1'b0, 32'h0000_0200,
          64'h2000_0000_0000_0000, 64'h2000_0000_0000_0001,
          64'h2000_0000_0000_0002, 64'h2000_0000_0000_0003, 1'b0, '0);
    pulse_rst("rst2");

    burst("wr 300 old", 1'b0, 1'b1, 32'h0000_0300,
          64'h0DD0_0000_0000_0000, 64'h0DD0_0000_0000_0001,
          64'h0DD0_0000_0000_0002, 64'h0DD0_0000_0000_0003, 1'b0, '0);
    pmem_write   = 1'b1;
    pmem_address = 32'h0000_0300;
    for (int c = 0; c <= LAT + 2; c++) begin
      if (c >= LAT)
        pmem_wdata = nw[c-LAT];
      if (c == LAT + 2)
        rst = 1'b1;
      @(negedge clk);
      chk($sformatf("rstmid resp c%0d", c), 64'(pmem_resp),
          64'(c == LAT || c == LAT + 1));
      @(posedge clk);
      #1;
    end
    chk("rstmid rdata", pmem_rdata, 64'h0);
    pmem_write = 1'b0;
    rst        = 1'b0;
    burst("rd 300", 1'b1, 1'b0, 32'h0000_0300,
          nw[0], nw[1],
          64'h0DD0_0000_0000_0002, 64'h0DD0_0000_0000_0003, 1'b0, '0);
    chk("rstmid err", 64'(proto_err), 64'h0);

    r1 = 1'b1;
    a1 = 32'h0000_0020;
    for (int c = 0; c <= 11; c++) begin
      if (c == 5)
        a1 = 32'h0000_0040;
      if (c == 11)
        r1 = 1'b0;
      exp1 = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      @(negedge clk);
      chk($sformatf("lat1 resp c%0d", c), 64'(resp1), 64'(exp1));
      @(posedge clk);
      #1;
    end
    chk("lat1 err", 64'(err1), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
